escaneo_zonas_temp: RTL and testbench

Round-robin scan controller that shares the single temperature-monitoring datapath (comparator + persistence register + state FSM) among N_ZONAS sensor zones. Periodically requests one sample per zone over a ready/valid handshake. Drives the captured sample onto the monitor's shared 11-bit signed input for RETENCION cycles so the persistence counter can evaluate it. Flags zones whose sensor does not respond in time.

---
 rtl/escaneo_zonas_temp.sv | 187 ++++++++++++++++++
 tb/tb_escaneo_zonas_temp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/escaneo_zonas_temp.sv
// Round-robin scan controller: shares one temperature monitor among N_ZONAS sensors.
// Optional zone masking is enabled by defining MASCARA_ZONAS_EN.
module escaneo_zonas_temp #(
    parameter int N_ZONAS   = 4,
    parameter int ANCHO     = 11,
    parameter int PERIODO   = 1000,
    parameter int RETENCION = 8,
    parameter int TIMEOUT   = 16,
    localparam int ZW       = $clog2(N_ZONAS)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        habilitar,
    input  logic [N_ZONAS-1:0]          sensor_valid,
    input  logic [N_ZONAS*ANCHO-1:0]    sensor_temp,
    output logic [N_ZONAS-1:0]          sensor_ready,
    input  logic                        limpiar_fallas,
`ifdef MASCARA_ZONAS_EN
    input  logic [N_ZONAS-1:0]          mascara_zona,
`endif
    output logic signed [ANCHO-1:0]     temp_salida,
    output logic                        temp_valida,
    output logic [ZW-1:0]               zona_sel,
    output logic [N_ZONAS-1:0]          falla_zona,
    output logic                        ciclo_completo
);

    localparam int MAX_PR  = (PERIODO > RETENCION) ? PERIODO : RETENCION;
    localparam int CNT_MAX = (MAX_PR > TIMEOUT) ? MAX_PR : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        INACTIVO,
        ESPERA,
        SOLICITA,
        ENTREGA,
        SIGUIENTE
    } estado_t;

    estado_t                        estado, estado_d;
    logic [CW-1:0]                  cnt, cnt_d;
    logic [ZW-1:0]                  zona_d;
    logic signed [ANCHO-1:0]        temp_d;
    logic [N_ZONAS-1:0]             falla_set;
    logic [N_ZONAS-1:0]             mascara;
    logic [N_ZONAS-1:0][ANCHO-1:0]  temp_z;

    assign temp_z = sensor_temp;

`ifdef MASCARA_ZONAS_EN
    assign mascara = mascara_zona;
`else
    assign mascara = '0;
`endif

    // First unmasked zone (scan start) and next unmasked zone after zona_sel.
    logic          hay_pri, hay_sig;
    logic [ZW-1:0] zona_pri, zona_sig;

    always_comb begin
        hay_pri  = 1'b0;
        zona_pri = '0;
        hay_sig  = 1'b0;
        zona_sig = '0;
        for (int z = N_ZONAS - 1; z >= 0; z--) begin
            if (!mascara[z]) begin
                hay_pri  = 1'b1;
                zona_pri = ZW'(z);
                if (z > int'(zona_sel)) begin
                    hay_sig  = 1'b1;
                    zona_sig = ZW'(z);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado      <= INACTIVO;
            cnt         <= '0;
            zona_sel    <= '0;
            temp_salida <= '0;
            falla_zona  <= '0;
        end else begin
            estado      <= estado_d;
            cnt         <= cnt_d;
            zona_sel    <= zona_d;
            temp_salida <= temp_d;
            falla_zona  <= (limpiar_fallas ? '0 : falla_zona) | falla_set;
        end
    end

    always_comb begin
        estado_d       = estado;
        cnt_d          = cnt;
        zona_d         = zona_sel;
        temp_d         = temp_salida;
        falla_set      = '0;
        sensor_ready   = '0;
        temp_valida    = 1'b0;
        ciclo_completo = 1'b0;

        case (estado)
            INACTIVO: begin
                cnt_d  = '0;
                zona_d = '0;
                if (habilitar) begin
                    // A fully masked scan still ends through SIGUIENTE to pulse ciclo_completo.
                    if (hay_pri) begin
                        estado_d = SOLICITA;
                        zona_d   = zona_pri;
                    end else begin
                        estado_d = SIGUIENTE;
                        zona_d   = ZW'(N_ZONAS - 1);
                    end
                end
            end

            ESPERA: begin
                if (!habilitar) begin
                    estado_d = INACTIVO;
                    zona_d   = '0;
                    cnt_d    = '0;
                end else if (cnt == CW'(PERIODO - 1)) begin
                    cnt_d = '0;
                    if (hay_pri) begin
                        estado_d = SOLICITA;
                        zona_d   = zona_pri;
                    end else begin
                        estado_d = SIGUIENTE;
                        zona_d   = ZW'(N_ZONAS - 1);
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            SOLICITA: begin
                sensor_ready[zona_sel] = 1'b1;
                // A transfer on the last allowed cycle wins over the timeout.
                if (sensor_valid[zona_sel]) begin
                    temp_d   = temp_z[zona_sel];
                    cnt_d    = '0;
                    estado_d = ENTREGA;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    falla_set[zona_sel] = 1'b1;
                    cnt_d    = '0;
                    estado_d = SIGUIENTE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            ENTREGA: begin
                temp_valida = 1'b1;
                if (cnt == CW'(RETENCION - 1)) begin
                    cnt_d    = '0;
                    estado_d = SIGUIENTE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            SIGUIENTE: begin
                cnt_d = '0;
                if (!hay_sig) begin
                    ciclo_completo = 1'b1;
                    zona_d   = '0;
                    estado_d = habilitar ? ESPERA : INACTIVO;
                end else if (!habilitar) begin
                    zona_d   = '0;
                    estado_d = INACTIVO;
                end else begin
                    zona_d   = zona_sig;
                    estado_d = SOLICITA;
                end
            end

            default: begin
                estado_d = INACTIVO;
                cnt_d    = '0;
                zona_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_escaneo_zonas_temp.sv
// Directed bench for escaneo_zonas_temp (N_ZONAS=4, RETENCION=8, TIMEOUT=16, PERIODO=1000).
module tb_escaneo_zonas_temp;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         habilitar = 1'b0;
    logic [3:0]   sv_en = 4'b1111;
    logic [3:0]   sensor_valid;
    logic [43:0]  sensor_temp;
    logic [3:0]   sensor_ready;
    logic         limpiar_fallas = 1'b0;
    logic [3:0]   mascara_zona = 4'b0000;
    logic signed [10:0] temp_salida;
    logic         temp_valida;
    logic [1:0]   zona_sel;
    logic [3:0]   falla_zona;
    logic         ciclo_completo;

    int n_vec = 0;
    int n_err = 0;
    int vals[4] = '{25, -10, 60, 0};

    assign sensor_valid = sv_en;
    // zone3=0, zone2=60, zone1=-10 (0x7F6), zone0=25
    assign sensor_temp = {11'd0, 11'd60, 11'h7F6, 11'd25};

    always #5 clk = ~clk;

    escaneo_zonas_temp dut (
        .clk(clk), .arst_n(arst_n), .habilitar(habilitar),
        .sensor_valid(sensor_valid), .sensor_temp(sensor_temp),
        .sensor_ready(sensor_ready), .limpiar_fallas(limpiar_fallas),
`ifdef MASCARA_ZONAS_EN
        .mascara_zona(mascara_zona),
`endif
        .temp_salida(temp_salida), .temp_valida(temp_valida),
        .zona_sel(zona_sel), .falla_zona(falla_zona),
        .ciclo_completo(ciclo_completo)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    // Entered while zone z is being requested; returns sampling its SIGUIENTE cycle.
    task automatic zona_ok(input int z, input int val);
        chk("sol_ready", int'(sensor_ready), 1 << z);
        chk("sol_zona", int'(zona_sel), z);
        for (int i = 0; i < 8; i++) begin
            ciclo();
            chk("ent_valida", int'(temp_valida), 1);
            chk("ent_temp", int'(temp_salida), val);
        end
        chk("ent_ready", int'(sensor_ready), 0);
        ciclo();
        chk("sig_valida", int'(temp_valida), 0);
        chk("sig_temp", int'(temp_salida), val);
    endtask

    task automatic zona_timeout(input int z);
        int n = 0;
        while (sensor_ready == 4'(1 << z) && n < 40) begin
            n++;
            ciclo();
        end
        chk("to_ready_cycles", n, 16);
    endtask

    task automatic esperar_solicitud(output int n);
        n = 0;
        while (sensor_ready == 4'b0 && n < 1200) begin
            ciclo();
            n++;
        end
        chk("espera_bound", int'(n < 1200), 1);
    endtask

    initial begin
        int n;
        int cc;

        // reset state
        #12;
        chk("rst_ready", int'(sensor_ready), 0);
        chk("rst_temp", int'(temp_salida), 0);
        chk("rst_valida", int'(temp_valida), 0);
        chk("rst_zona", int'(zona_sel), 0);
        chk("rst_falla", int'(falla_zona), 0);
        chk("rst_cc", int'(ciclo_completo), 0);
        ciclo();
        arst_n = 1'b1;
        ciclo();
        chk("idle_ready", int'(sensor_ready), 0);

        // full scan, all sensors ready
        habilitar = 1'b1;
        ciclo();
        for (int z = 0; z < 4; z++) begin
            zona_ok(z, vals[z]);
            chk("cc_pulse", int'(ciclo_completo), (z == 3) ? 1 : 0);
            if (z < 3) ciclo();
        end

        // PERIODO idle cycles before zone 0 again; zone 2 goes silent for next scan
        sv_en = 4'b1011;
        n = 0;
        cc = 0;
        do begin
            ciclo();
            n++;
            if (ciclo_completo) cc++;
        end while (sensor_ready == 4'b0 && n < 1200);
        chk("periodo", n, 1001);
        chk("espera_cc", cc, 0);

        // zone 2 timeout
        zona_ok(0, 25);
        ciclo();
        zona_ok(1, -10);
        ciclo();
        zona_timeout(2);
        chk("to_falla", int'(falla_zona), 4'b0100);
        chk("to_temp_hold", int'(temp_salida), -10);
        chk("to_valida", int'(temp_valida), 0);
        ciclo();
        zona_ok(3, 0);
        chk("cc_pulse2", int'(ciclo_completo), 1);

        // clear coincident with zone 1 timeout: set wins, others cleared
        sv_en = 4'b1001;
        esperar_solicitud(n);
        zona_ok(0, 25);
        ciclo();
        for (int i = 0; i < 15; i++) begin
            chk("z1_ready", int'(sensor_ready), 4'b0010);
            ciclo();
        end
        chk("z1_ready_last", int'(sensor_ready), 4'b0010);
        limpiar_fallas = 1'b1;
        ciclo();
        limpiar_fallas = 1'b0;
        chk("clr_set_wins", int'(falla_zona), 4'b0010);
        ciclo();
        zona_timeout(2);
        chk("falla_1_2", int'(falla_zona), 4'b0110);
        ciclo();
        zona_ok(3, 0);
        chk("cc_pulse3", int'(ciclo_completo), 1);

        // habilitar dropped during zone 1 delivery
        sv_en = 4'b1111;
        esperar_solicitud(n);
        zona_ok(0, 25);
        ciclo();
        chk("z1_sol", int'(sensor_ready), 4'b0010);
        ciclo();
        chk("z1_ent_temp", int'(temp_salida), -10);
        habilitar = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ciclo();
            chk("drop_valida", int'(temp_valida), 1);
        end
        ciclo();
        chk("drop_sig_valida", int'(temp_valida), 0);
        chk("drop_no_cc", int'(ciclo_completo), 0);
        ciclo();
        chk("drop_ready", int'(sensor_ready), 0);
        chk("drop_zona", int'(zona_sel), 0);
        repeat (3) ciclo();
        chk("inact_ready", int'(sensor_ready), 0);

        // async reset while requesting zone 3
        sv_en = 4'b0111;
        habilitar = 1'b1;
        ciclo();
        zona_ok(0, 25);
        ciclo();
        zona_ok(1, -10);
        ciclo();
        zona_ok(2, 60);
        ciclo();
        chk("z3_sol", int'(sensor_ready), 4'b1000);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_ready", int'(sensor_ready), 0);
        chk("arst_temp", int'(temp_salida), 0);
        chk("arst_zona", int'(zona_sel), 0);
        chk("arst_falla", int'(falla_zona), 0);
        chk("arst_valida", int'(temp_valida), 0);
        ciclo();
        arst_n = 1'b1;
        sv_en = 4'b1111;
        ciclo();
        chk("restart_ready", int'(sensor_ready), 4'b0001);
        chk("restart_zona", int'(zona_sel), 0);

`ifdef MASCARA_ZONAS_EN
        // mask 1010: only zones 0 and 2
        arst_n = 1'b0;
        mascara_zona = 4'b1010;
        ciclo();
        arst_n = 1'b1;
        ciclo();
        zona_ok(0, 25);
        chk("m_cc0", int'(ciclo_completo), 0);
        ciclo();
        zona_ok(2, 60);
        chk("m_cc", int'(ciclo_completo), 1);
        // all masked: immediate end of scan
        arst_n = 1'b0;
        mascara_zona = 4'b1111;
        ciclo();
        arst_n = 1'b1;
        ciclo();
        chk("mall_ready", int'(sensor_ready), 0);
        chk("mall_cc", int'(ciclo_completo), 1);
        ciclo();
        chk("mall_ready2", int'(sensor_ready), 0);
        chk("mall_falla", int'(falla_zona), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
